pc_sequencer: RTL and testbench

//   Control FSM for the program-counter datapath. Each cycle it issues exactly one command to
//   the PC register: hold, increment or load. Commands come from run/halt control and from

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_ret_stack.sv | 53 +++++
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer: FSM state encoding,
// PC command selects and default sizing.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_INC  = 2'd1,
        CMD_LOAD = 2'd2
    } cmd_t;

    localparam int PC_W_DEF        = 8;
    localparam int STACK_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for pc_sequencer: push/pop with top, full, empty and occupancy count.
// Occupancy is cleared by async reset or by a synchronous clear; entries are never reset.
module pc_ret_stack #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [PC_W-1:0]          push_data,
    output logic [PC_W-1:0]          top,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0] mem [DEPTH];
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   top_pos;
    logic [AW-1:0]   top_idx;

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == '0);
    assign count   = count_r;
    assign top_pos = count_r - CW'(1);
    assign top_idx = top_pos[AW-1:0];
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (push && !full) begin
            count_r <= count_r + CW'(1);
        end else if (pop && !empty) begin
            count_r <= count_r - CW'(1);
        end
    end

    // Storage carries data only, so it is written without reset.
    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            mem[count_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter control FSM: issues one hold/increment/load command per cycle from
// run/halt control and jump/call/return requests. Macro PC_SEQ_CALL_STACK_EN enables the call stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic                           start,
    input  logic                           halt_req,
    input  logic                           jmp_valid,
    input  logic                           call,
    input  logic                           ret,
    input  logic [PC_W-1:0]                jmp_addr,
    input  logic [PC_W-1:0]                pc_cur,
    output logic                           pc_inc,
    output logic                           pc_load,
    output logic [PC_W-1:0]                pc_load_val,
    output logic [1:0]                     state_o,
    output logic                           fault,
    output logic [$clog2(STACK_DEPTH):0]   sp_depth
);

    state_t          state;
    state_t          state_n;
    cmd_t            cmd;
    logic [PC_W-1:0] load_val;
    logic            stk_push;
    logic            stk_pop;
    logic            stk_clear;
    logic [PC_W-1:0] stk_top;
    logic            stk_full;
    logic            stk_empty;

`ifdef PC_SEQ_CALL_STACK_EN
    pc_ret_stack #(
        .PC_W  (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_cur + PC_W'(1)),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .count     (sp_depth)
    );

    assign fault = (state == ST_FAULT);
`else
    logic unused_stk;

    assign stk_top    = '0;
    assign stk_full   = 1'b0;
    assign stk_empty  = 1'b1;
    assign sp_depth   = '0;
    assign fault      = 1'b0;
    assign unused_stk = ^{ret, pc_cur, stk_push, stk_pop, stk_clear, stk_top, stk_full, stk_empty};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        cmd       = CMD_HOLD;
        load_val  = '0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = 1'b0;
        if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (start) state_n = ST_RUN;
                end
                ST_RUN: begin
                    // A halt drops any same-cycle jump/call/return.
                    if (halt_req) begin
                        state_n = ST_HALT;
`ifdef PC_SEQ_CALL_STACK_EN
                    end else if (ret) begin
                        if (!stk_empty) begin
                            cmd      = CMD_LOAD;
                            load_val = stk_top;
                            stk_pop  = 1'b1;
                        end else begin
                            state_n = ST_FAULT;
                        end
                    end else if (call) begin
                        if (!stk_full) begin
                            cmd      = CMD_LOAD;
                            load_val = jmp_addr;
                            stk_push = 1'b1;
                        end else begin
                            state_n = ST_FAULT;
                        end
                    end else if (jmp_valid) begin
                        cmd      = CMD_LOAD;
                        load_val = jmp_addr;
`else
                    end else if (call || jmp_valid) begin
                        cmd      = CMD_LOAD;
                        load_val = jmp_addr;
`endif
                    end else begin
                        cmd = CMD_INC;
                    end
                end
                ST_HALT: begin
                    if (start && !halt_req) state_n = ST_RUN;
                end
                ST_FAULT: begin
                    if (start) begin
                        state_n   = ST_IDLE;
                        stk_clear = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign pc_inc      = (cmd == CMD_INC);
    assign pc_load     = (cmd == CMD_LOAD);
    assign pc_load_val = load_val;
    assign state_o     = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expectations adapt to PC_SEQ_CALL_STACK_EN.
module tb_pc_sequencer;

`ifdef PC_SEQ_CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, ena, start, halt_req, jmp_valid, call, ret;
    logic [7:0] jmp_addr, pc_cur;
    logic       pc_inc, pc_load, fault;
    logic [7:0] pc_load_val;
    logic [1:0] state_o;
    logic [2:0] sp_depth;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.PC_W(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .halt_req(halt_req),
        .jmp_valid(jmp_valid), .call(call), .ret(ret), .jmp_addr(jmp_addr), .pc_cur(pc_cur),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val), .state_o(state_o),
        .fault(fault), .sp_depth(sp_depth)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; halt_req = 1'b0; jmp_valid = 1'b0;
        call = 1'b0; ret = 1'b0; jmp_addr = 8'h00; pc_cur = 8'h00;
        #2;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
        checks++; if (sp_depth !== 3'd0) begin errors++; $display("FAIL reset_sp got %0d want 0", sp_depth); end
        checks++; if ({pc_inc, pc_load, fault, pc_load_val} !== 11'd0) begin errors++;
            $display("FAIL reset_outs got inc=%b load=%b fault=%b val=%h want all 0", pc_inc, pc_load, fault, pc_load_val); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_run_halt();
        start = 1'b1; pc_cur = 8'h10;
        #1;
        checks++; if (pc_inc !== 1'b0) begin errors++; $display("FAIL idle_inc got %b want 0", pc_inc); end
        tick(); start = 1'b0;
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL start_run got %0d want 1", state_o); end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (pc_inc !== 1'b1 || pc_load !== 1'b0) begin errors++;
                $display("FAIL run_inc[%0d] got inc=%b load=%b want inc=1 load=0", i, pc_inc, pc_load); end
            tick(); pc_cur = pc_cur + 8'd1;
        end
        halt_req = 1'b1;
        #1;
        checks++; if (pc_inc !== 1'b0 || pc_load !== 1'b0) begin errors++;
            $display("FAIL halt_cmd got inc=%b load=%b want 0 0", pc_inc, pc_load); end
        tick(); halt_req = 1'b0;
        checks++; if (state_o !== 2'd2 || pc_inc !== 1'b0) begin errors++;
            $display("FAIL halt_state got st=%0d inc=%b want st=2 inc=0", state_o, pc_inc); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL halt_restart got %0d want 1", state_o); end
    endtask

    task automatic test_jump();
        jmp_valid = 1'b1; jmp_addr = 8'h3C;
        #1;
        checks++; if (pc_load !== 1'b1 || pc_inc !== 1'b0 || pc_load_val !== 8'h3C) begin errors++;
            $display("FAIL jump_cmd got load=%b inc=%b val=%h want 1 0 3c", pc_load, pc_inc, pc_load_val); end
        tick(); jmp_valid = 1'b0;
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL jump_state got %0d want 1", state_o); end
    endtask

    task automatic test_call_ret();
        pc_cur = 8'h20; call = 1'b1; jmp_addr = 8'h80;
        #1;
        checks++; if (pc_load !== 1'b1 || pc_load_val !== 8'h80) begin errors++;
            $display("FAIL call_cmd got load=%b val=%h want 1 80", pc_load, pc_load_val); end
        tick(); call = 1'b0; pc_cur = 8'h80;
        checks++; if (sp_depth !== (STK ? 3'd1 : 3'd0)) begin errors++;
            $display("FAIL call_sp got %0d want %0d", sp_depth, STK ? 1 : 0); end
        tick(); pc_cur = 8'h81;
        ret = 1'b1;
        #1;
        checks++; if (pc_load !== STK || pc_inc !== !STK || pc_load_val !== (STK ? 8'h21 : 8'h00)) begin errors++;
            $display("FAIL ret_cmd got load=%b inc=%b val=%h want load=%b val=%h", pc_load, pc_inc, pc_load_val, STK, STK ? 8'h21 : 8'h00); end
        tick(); ret = 1'b0;
        checks++; if (sp_depth !== 3'd0 || state_o !== 2'd1) begin errors++;
            $display("FAIL ret_sp got sp=%0d st=%0d want 0 1", sp_depth, state_o); end
    endtask

    task automatic test_overflow();
        pc_cur = 8'hFF; call = 1'b1; jmp_addr = 8'h05;
        #1;
        checks++; if (pc_load !== 1'b1 || pc_load_val !== 8'h05) begin errors++;
            $display("FAIL wrapcall_cmd got load=%b val=%h want 1 05", pc_load, pc_load_val); end
        tick(); call = 1'b0; pc_cur = 8'h05; ret = 1'b1; jmp_addr = 8'h77;
        #1;
        checks++; if (pc_load !== STK || pc_load_val !== 8'h00) begin errors++;
            $display("FAIL wrap_ret got load=%b val=%h want load=%b val=00", pc_load, pc_load_val, STK); end
        tick(); ret = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_cur = 8'h40 + 8'(i); jmp_addr = 8'h50 + 8'(i); call = 1'b1;
            #1;
            checks++; if (pc_load !== 1'b1 || pc_load_val !== 8'h50 + 8'(i)) begin errors++;
                $display("FAIL fill_call[%0d] got load=%b val=%h want 1 %h", i, pc_load, pc_load_val, 8'h50 + 8'(i)); end
            tick();
        end
        checks++; if (sp_depth !== (STK ? 3'd4 : 3'd0)) begin errors++;
            $display("FAIL full_sp got %0d want %0d", sp_depth, STK ? 4 : 0); end
        jmp_addr = 8'h99;
        #1;
        checks++; if (pc_load !== !STK) begin errors++; $display("FAIL over_cmd got load=%b want %b", pc_load, !STK); end
        tick(); call = 1'b0;
        checks++; if (state_o !== (STK ? 2'd3 : 2'd1) || fault !== STK) begin errors++;
            $display("FAIL over_fault got st=%0d fault=%b want st=%0d fault=%b", state_o, fault, STK ? 3 : 1, STK); end
        #1;
        checks++; if (pc_inc !== !STK || pc_load !== 1'b0) begin errors++;
            $display("FAIL fault_cmd got inc=%b load=%b want inc=%b load=0", pc_inc, pc_load, !STK); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (state_o !== (STK ? 2'd0 : 2'd1) || sp_depth !== 3'd0 || fault !== 1'b0) begin errors++;
            $display("FAIL fault_clear got st=%0d sp=%0d fault=%b want st=%0d sp=0 fault=0", state_o, sp_depth, fault, STK ? 0 : 1); end
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic test_priority();
        pc_cur = 8'h30; call = 1'b1; jmp_addr = 8'h60;
        tick(); call = 1'b0;
        halt_req = 1'b1; ret = 1'b1; jmp_valid = 1'b1; jmp_addr = 8'h11;
        #1;
        checks++; if (pc_inc !== 1'b0 || pc_load !== 1'b0 || pc_load_val !== 8'h00) begin errors++;
            $display("FAIL prio_cmd got inc=%b load=%b val=%h want 0 0 00", pc_inc, pc_load, pc_load_val); end
        tick(); halt_req = 1'b0; ret = 1'b0; jmp_valid = 1'b0;
        checks++; if (state_o !== 2'd2 || sp_depth !== (STK ? 3'd1 : 3'd0)) begin errors++;
            $display("FAIL prio_state got st=%0d sp=%0d want st=2 sp=%0d", state_o, sp_depth, STK ? 1 : 0); end
        start = 1'b1; tick(); start = 1'b0;
        ena = 1'b0; jmp_valid = 1'b1; halt_req = 1'b1;
        #1;
        checks++; if (pc_inc !== 1'b0 || pc_load !== 1'b0) begin errors++;
            $display("FAIL ena_cmd got inc=%b load=%b want 0 0", pc_inc, pc_load); end
        tick(); jmp_valid = 1'b0; halt_req = 1'b0;
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL ena_hold got %0d want 1", state_o); end
        ena = 1'b1; ret = 1'b1;
        #1;
        checks++; if (pc_load !== STK || pc_load_val !== (STK ? 8'h31 : 8'h00)) begin errors++;
            $display("FAIL pop_cmd got load=%b val=%h want %b %h", pc_load, pc_load_val, STK, STK ? 8'h31 : 8'h00); end
        tick();
        #1;
        checks++; if (pc_load !== 1'b0 || pc_inc !== !STK) begin errors++;
            $display("FAIL empty_ret_cmd got load=%b inc=%b want 0 %b", pc_load, pc_inc, !STK); end
        tick(); ret = 1'b0;
        checks++; if (state_o !== (STK ? 2'd3 : 2'd1) || fault !== STK) begin errors++;
            $display("FAIL empty_ret_fault got st=%0d fault=%b want %0d %b", state_o, fault, STK ? 3 : 1, STK); end
        start = 1'b1; tick(); tick(); start = 1'b0;
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL recover_run got %0d want 1", state_o); end
    endtask

    task automatic test_reset_mid();
        call = 1'b1; pc_cur = 8'h20; jmp_addr = 8'h80;
        tick(); pc_cur = 8'h80;
        tick(); call = 1'b0;
        checks++; if (sp_depth !== (STK ? 3'd2 : 3'd0)) begin errors++;
            $display("FAIL mid_sp got %0d want %0d", sp_depth, STK ? 2 : 0); end
        jmp_valid = 1'b1; jmp_addr = 8'hAA;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pc_load !== 1'b0 || pc_inc !== 1'b0 || pc_load_val !== 8'h00) begin errors++;
            $display("FAIL arst_cmd got inc=%b load=%b val=%h want 0 0 00", pc_inc, pc_load, pc_load_val); end
        checks++; if (state_o !== 2'd0 || sp_depth !== 3'd0 || fault !== 1'b0) begin errors++;
            $display("FAIL arst_state got st=%0d sp=%0d fault=%b want 0 0 0", state_o, sp_depth, fault); end
        jmp_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL post_rst got %0d want 0", state_o); end
    endtask

    initial begin
        test_reset();
        test_run_halt();
        test_jump();
        test_call_ret();
        test_overflow();
        test_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
